// File: rtl/soc_mem_map_pkg.sv
// Shared SoC memory map: default region bases/sizes and fetch bridge FSM types.
package soc_mem_map_pkg;

   localparam logic [31:0] ROM_BASE_DEF  = 32'h0000_0000;
   localparam logic [31:0] ROM_SIZE_DEF  = 32'h0000_0200;
   localparam logic [31:0] IRAM_BASE_DEF = 32'h0010_0000;
   localparam logic [31:0] IRAM_SIZE_DEF = 32'h0001_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      ERR  = 2'd3
   } fetch_state_e;

   typedef enum logic {
      SEL_ROM  = 1'b0,
      SEL_IRAM = 1'b1
   } tgt_sel_e;

endpackage

// File: rtl/addr_decoder.sv
// Combinational region match for the fetch bridge; zero latency, no flow control.
module addr_decoder
   import soc_mem_map_pkg::*;
#(
   parameter logic [31:0] ROM_BASE  = ROM_BASE_DEF,
   parameter logic [31:0] ROM_SIZE  = ROM_SIZE_DEF,
   parameter logic [31:0] IRAM_BASE = IRAM_BASE_DEF,
   parameter logic [31:0] IRAM_SIZE = IRAM_SIZE_DEF
) (
   input  logic [31:0] addr_i,
   output logic        hit_rom,
   output logic        hit_iram,
   output logic [31:0] offset
);

   // The borrow bit rejects addresses below the base, so no compare can wrap.
   logic [32:0] rom_diff;
   logic [32:0] iram_diff;
   logic        rom_match;
   logic        iram_match;

   assign rom_diff   = {1'b0, addr_i} - {1'b0, ROM_BASE};
   assign iram_diff  = {1'b0, addr_i} - {1'b0, IRAM_BASE};
   assign rom_match  = !rom_diff[32]  && (rom_diff[31:0]  < ROM_SIZE);
   assign iram_match = !iram_diff[32] && (iram_diff[31:0] < IRAM_SIZE);

   assign hit_rom  = rom_match;
   assign hit_iram = iram_match && !rom_match;
   assign offset   = rom_match  ? rom_diff[31:0]  :
                     iram_match ? iram_diff[31:0] : 32'h0000_0000;

endmodule

// File: rtl/instr_fetch_bridge.sv
// OBI instruction fetch to two AXI-style read ports (ROM, IRAM), one outstanding fetch.
// Grant on AR handshake (or immediately on decode miss); new requests wait until back in IDLE.
module instr_fetch_bridge
   import soc_mem_map_pkg::*;
#(
   parameter logic [31:0] ROM_BASE  = ROM_BASE_DEF,
   parameter logic [31:0] ROM_SIZE  = ROM_SIZE_DEF,
   parameter logic [31:0] IRAM_BASE = IRAM_BASE_DEF,
   parameter logic [31:0] IRAM_SIZE = IRAM_SIZE_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   output logic [31:0] rom_araddr_o,
   output logic        rom_arvalid_o,
   input  logic        rom_arready_i,
   input  logic [31:0] rom_rdata_i,
   input  logic        rom_rvalid_i,
   output logic        rom_rready_o,
   output logic [31:0] iram_araddr_o,
   output logic        iram_arvalid_o,
   input  logic        iram_arready_i,
   input  logic [31:0] iram_rdata_i,
   input  logic        iram_rvalid_i,
   output logic        iram_rready_o
);

   fetch_state_e state_q, state_d;
   tgt_sel_e     sel_q, sel_d;
   logic [31:0]  off_q, off_d;
   logic         rom_arvalid_q, rom_arvalid_d;
   logic         iram_arvalid_q, iram_arvalid_d;
   logic         rom_rready_q, rom_rready_d;
   logic         iram_rready_q, iram_rready_d;

   logic         dec_hit_rom;
   logic         dec_hit_iram;
   logic [31:0]  dec_offset;
   logic         sel_arready;
   logic         sel_rvalid;
   logic [31:0]  sel_rdata;

   addr_decoder #(
      .ROM_BASE  (ROM_BASE),
      .ROM_SIZE  (ROM_SIZE),
      .IRAM_BASE (IRAM_BASE),
      .IRAM_SIZE (IRAM_SIZE)
   ) u_addr_decoder (
      .addr_i   (instr_addr_i),
      .hit_rom  (dec_hit_rom),
      .hit_iram (dec_hit_iram),
      .offset   (dec_offset)
   );

   // Only the latched target's handshake signals are ever looked at.
   assign sel_arready = (sel_q == SEL_IRAM) ? iram_arready_i : rom_arready_i;
   assign sel_rvalid  = (sel_q == SEL_IRAM) ? iram_rvalid_i  : rom_rvalid_i;
   assign sel_rdata   = (sel_q == SEL_IRAM) ? iram_rdata_i   : rom_rdata_i;

   always_comb begin
      state_d        = state_q;
      sel_d          = sel_q;
      off_d          = off_q;
      rom_arvalid_d  = rom_arvalid_q;
      iram_arvalid_d = iram_arvalid_q;
      rom_rready_d   = rom_rready_q;
      iram_rready_d  = iram_rready_q;
      instr_gnt_o    = 1'b0;
      instr_rvalid_o = 1'b0;
      instr_rdata_o  = 32'h0000_0000;
      instr_err_o    = 1'b0;
      case (state_q)
         IDLE: begin
            if (instr_req_i) begin
               off_d = dec_offset;
               sel_d = dec_hit_iram ? SEL_IRAM : SEL_ROM;
               if (dec_hit_rom || dec_hit_iram) begin
                  rom_arvalid_d  = dec_hit_rom;
                  iram_arvalid_d = dec_hit_iram;
                  state_d        = ADDR;
               end else begin
                  instr_gnt_o = 1'b1;
                  state_d     = ERR;
               end
            end
         end
         ADDR: begin
            if (sel_arready) begin
               instr_gnt_o    = 1'b1;
               rom_arvalid_d  = 1'b0;
               iram_arvalid_d = 1'b0;
               rom_rready_d   = (sel_q == SEL_ROM);
               iram_rready_d  = (sel_q == SEL_IRAM);
               state_d        = DATA;
            end
         end
         DATA: begin
            if (sel_rvalid) begin
               instr_rvalid_o = 1'b1;
               instr_rdata_o  = sel_rdata;
               rom_rready_d   = 1'b0;
               iram_rready_d  = 1'b0;
               state_d        = IDLE;
            end
         end
         ERR: begin
            instr_rvalid_o = 1'b1;
            instr_err_o    = 1'b1;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         sel_q          <= SEL_ROM;
         off_q          <= 32'h0000_0000;
         rom_arvalid_q  <= 1'b0;
         iram_arvalid_q <= 1'b0;
         rom_rready_q   <= 1'b0;
         iram_rready_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         sel_q          <= sel_d;
         off_q          <= off_d;
         rom_arvalid_q  <= rom_arvalid_d;
         iram_arvalid_q <= iram_arvalid_d;
         rom_rready_q   <= rom_rready_d;
         iram_rready_q  <= iram_rready_d;
      end
   end

   assign rom_arvalid_o  = rom_arvalid_q;
   assign iram_arvalid_o = iram_arvalid_q;
   assign rom_araddr_o   = rom_arvalid_q  ? off_q : 32'h0000_0000;
   assign iram_araddr_o  = iram_arvalid_q ? off_q : 32'h0000_0000;
   assign rom_rready_o   = rom_rready_q;
   assign iram_rready_o  = iram_rready_q;

endmodule
